// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs, ALU ops,
// FSM states, trap causes and the decoded-instruction bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b001010;
  localparam logic [5:0] OP_BGT   = 6'b001011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_FETCH   = 2'b01;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b10;
  localparam logic [1:0] TRAP_JR      = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GT
  } br_kind_t;

  typedef struct packed {
    logic       legal;
    logic       is_rtype;
    logic       is_branch;
    logic       is_jr;
    logic       alu_src;
    logic [1:0] alu_op;
    br_kind_t   br_kind;
  } dec_t;

  // Branch displacement: word offset sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational instruction classifier: opcode/funct -> legality, class,
// ALU controls and branch kind. No state, zero latency.
module mips_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.is_rtype = 1'b1;
        case (i_funct)
          FN_ADD: begin o_dec.legal = 1'b1; o_dec.alu_op = ALU_ADD; end
          FN_SUB: begin o_dec.legal = 1'b1; o_dec.alu_op = ALU_SUB; end
          FN_AND: begin o_dec.legal = 1'b1; o_dec.alu_op = ALU_AND; end
          FN_SLT: begin o_dec.legal = 1'b1; o_dec.alu_op = ALU_SLT; end
          FN_JR:  begin o_dec.legal = 1'b1; o_dec.is_jr  = 1'b1;    end
          default: ;
        endcase
      end
      OP_ADDI: begin
        o_dec.legal   = 1'b1;
        o_dec.alu_src = 1'b1;
        o_dec.alu_op  = ALU_ADD;
      end
      OP_BEQ: begin
        o_dec.legal     = 1'b1;
        o_dec.is_branch = 1'b1;
        o_dec.alu_op    = ALU_SUB;
        o_dec.br_kind   = BR_EQ;
      end
      OP_BNE: begin
        o_dec.legal     = 1'b1;
        o_dec.is_branch = 1'b1;
        o_dec.alu_op    = ALU_SUB;
        o_dec.br_kind   = BR_NE;
      end
      // Signed compares use the SLT path so alu_lt is meaningful.
      OP_BLT: begin
        o_dec.legal     = 1'b1;
        o_dec.is_branch = 1'b1;
        o_dec.alu_op    = ALU_SLT;
        o_dec.br_kind   = BR_LT;
      end
      OP_BGT: begin
        o_dec.legal     = 1'b1;
        o_dec.is_branch = 1'b1;
        o_dec.alu_op    = ALU_SLT;
        o_dec.br_kind   = BR_GT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle sequencer: owns PC and IR, fetches over req/ack, drives Moore
// datapath controls per state and traps on timeout, illegal op or bad JR target.
module mips_mc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [4:0]  wr_addr,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic        retired,
  output logic        halted,
  output logic [1:0]  trap_cause
);

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ir, w_ir_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_cause, w_cause_nxt;

  dec_t        w_dec;
  logic        w_taken;
  logic [31:0] w_pc_seq;

  mips_decode u_decode (
    .i_opcode (r_ir[31:26]),
    .i_funct  (r_ir[5:0]),
    .o_dec    (w_dec)
  );

  assign w_pc_seq = r_pc + 32'd4;

  always_comb begin
    w_taken = 1'b0;
    case (w_dec.br_kind)
      BR_EQ: w_taken = alu_zero;
      BR_NE: w_taken = !alu_zero;
      BR_LT: w_taken = alu_lt;
      BR_GT: w_taken = !alu_lt && !alu_zero;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_cause <= TRAP_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    imem_req    = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    reg_write   = 1'b0;
    wr_addr     = 5'd0;
    retired     = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_ir_nxt    = imem_rdata;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DECODE;
        end else if (r_cnt == TMO_LAST) begin
          w_cause_nxt = TRAP_FETCH;
          w_state_nxt = S_TRAP;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        if (w_dec.legal) begin
          w_state_nxt = S_EXECUTE;
        end else begin
          w_cause_nxt = TRAP_ILLEGAL;
          w_state_nxt = S_TRAP;
        end
      end
      S_EXECUTE: begin
        alu_src = w_dec.alu_src;
        alu_op  = w_dec.alu_op;
        if (w_dec.is_jr) begin
          // Misaligned targets trap before the PC is touched.
          if (rs_data[1:0] != 2'b00) begin
            w_cause_nxt = TRAP_JR;
            w_state_nxt = S_TRAP;
          end else begin
            w_pc_nxt    = rs_data;
            retired     = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end else if (w_dec.is_branch) begin
          w_pc_nxt    = w_taken ? (w_pc_seq + branch_offset(r_ir[15:0])) : w_pc_seq;
          retired     = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        alu_src     = w_dec.alu_src;
        alu_op      = w_dec.alu_op;
        reg_write   = 1'b1;
        wr_addr     = w_dec.is_rtype ? r_ir[15:11] : r_ir[20:16];
        w_pc_nxt    = w_pc_seq;
        retired     = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: begin
        w_state_nxt = S_TRAP;
      end
    endcase
  end

  assign imem_addr  = imem_req ? r_pc : 32'd0;
  assign instr      = r_ir;
  assign pc         = r_pc;
  assign trap_cause = r_cause;

endmodule

// File: doc/mips_mc_sequencer.md
Name: mips_mc_sequencer

Overview:
Multi-cycle instruction sequencer for the non-pipelined MIPS datapath. Owns the PC, fetches words over a req/ack instruction-memory port, and latches each into an instruction register (IR). Drives per-state datapath controls (alu_src, alu_op, reg_write, write address) and resolves BEQ/BNE/BLT/BGT/JR from datapath flags. Sits between instruction memory and the Datapath, replacing the free-running PC+4.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before trapping (range 2..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request; high for every cycle in FETCH
imem_addr  out  32  equals pc while imem_req=1, else 0
imem_ack  in  1  fetch data valid; sampled only in FETCH
imem_rdata  in  32  instruction word, valid with imem_ack
instr  out  32  IR contents, to datapath field extraction
alu_src  out  1  1 = sign-extended immediate as operand B
alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 SLT
reg_write  out  1  register-file write strobe
wr_addr  out  5  rd for R-type, rt for ADDI
alu_zero  in  1  combinational: operand A == operand B
alu_lt  in  1  combinational: signed A < signed B
rs_data  in  32  register[rs], for JR
pc  out  32  current PC
retired  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky trap indicator
trap_cause  out  2  00 none, 01 fetch timeout, 10 illegal opcode/funct, 11 misaligned JR target

Behaviour:
- Reset (async, any state, mid-fetch included): state=FETCH, pc=RESET_PC, IR=0, timeout counter=0, trap_cause=00. Outputs: imem_req=1, imem_addr=RESET_PC, alu_src=0, alu_op=00, reg_write=0, wr_addr=0, retired=0, halted=0. An in-flight ack arriving during reset is dropped.
- States: FETCH, DECODE, EXECUTE, WRITEBACK, TRAP. All controls are Moore outputs of the state and IR.
- FETCH: imem_req=1. When imem_ack=1: IR<=imem_rdata, counter cleared, ->DECODE. Same-cycle ack is legal (zero wait). Otherwise counter increments. If counter reaches FETCH_TIMEOUT-1 with no ack: ->TRAP, cause 01.
- DECODE: one cycle. Legal instructions are R-type funct ADD/SUB/AND/SLT/JR and opcodes ADDI/BEQ/BNE/BLT(001010)/BGT(001011). Anything else ->TRAP, cause 10, pc unchanged. Otherwise ->EXECUTE.
- EXECUTE, ALU ops: drive alu_src and alu_op per instruction (ADDI alu_src=1, op 00). ->WRITEBACK.
- WRITEBACK: same alu_src/alu_op held; reg_write=1; wr_addr=rd (R-type) or rt (ADDI). pc<=pc+4; retired=1; ->FETCH. A write to register 0 is still strobed; the register file ignores it.
- EXECUTE, branches: alu_src=0. alu_op=01 for BEQ/BNE, 11 for BLT/BGT. Taken conditions: BEQ zero; BNE !zero; BLT lt; BGT !lt && !zero.
  - Taken: pc<=pc+4+(sext(imm16)<<2). Not taken: pc<=pc+4.
  - retired=1; ->FETCH. Branch latency is 3 cycles plus fetch waits.
- EXECUTE, JR: if rs_data[1:0]!=0: ->TRAP, cause 11, pc unchanged. Else pc<=rs_data, retired=1, ->FETCH.
- PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- TRAP: halted=1; all strobes 0; imem_req=0; pc frozen. Only reset exits.
- Minimum ALU-instruction latency is 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).

Decomposition:
- Package mips_pkg: opcode/funct localparams, alu_op encoding, state enum (state_t), trap_cause encoding.
- Sub-module mips_decode: combinational IR -> {legal, is_rtype, is_branch, is_jr, alu_src, alu_op, branch kind}.
- Sequencer FSM, PC register and timeout counter stay in mips_mc_sequencer.

Test Plan:
- Zero-wait ADD r3,r1,r2 at pc=0, ack same cycle -> reg_write=1 only in cycle 4, wr_addr=3, alu_op=00, retired at cycle 4, pc=4.
- ADDI rt=5, imm=16'hFFFF, ack delayed 3 cycles -> alu_src=1 in EXECUTE and WRITEBACK, wr_addr=5, retired 6 cycles after first imem_req.
- BEQ at pc=8 with imm=16'hFFFE: alu_zero=1 -> pc=4; alu_zero=0 -> pc=12; reg_write never asserted.
- BGT with alu_lt=0, alu_zero=0, imm=3 at pc=0x20 -> pc=0x30. Same instruction with alu_zero=1 -> pc=0x24.
- JR with rs_data=0x100 -> pc=0x100. JR with rs_data=0x102 -> halted=1, trap_cause=11, imem_req=0 thereafter.
- No ack for FETCH_TIMEOUT cycles -> TRAP, cause 01. Opcode 6'b111111 -> cause 10. Assert reset mid-WRITEBACK -> all outputs at reset values immediately, pc=RESET_PC.
